dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the CPU load/store port (port A) and a DMA/debug loader (port B). It grants at most one access per cycle, drives the memory's address, write-enable and write-data inputs, and returns registered read data to the winning requester. Port B may lock the memory for bounded bursts. The block sits between the CPU datapath and the data memory, which has combinational read, a write on posedge `clk`, and word index = byte address / 4.

## Interface
- `MAX_BURST`, default 16: maximum consecutive locked B beats before A is given one slot (A must have a request pending); range 1..255.
- `clk`  in  1  system clock; all state updates on posedge.
- `resetn`  in  1  synchronous, active-low reset.
- `a_req`  in  1  port A access request; held with its fields until `a_gnt`.
- `a_we`  in  1  port A write (1) or read (0).
- `a_addr`  in  32  port A byte address.
- `a_wdata`  in  32  port A write data.
- `a_gnt`  out  1  port A access performed this cycle.
- `a_rdata`  out  32  port A read data; valid while `a_rvalid` is 1.
- `a_rvalid`  out  1  one-cycle pulse, cycle after a granted A read.
- `b_req`, `b_we`, `b_addr`[32], `b_wdata`[32]  in  port B equivalents.
- `b_lock`  in  1  sampled with a granted B beat; 1 = keep ownership for the next beat.
- `b_gnt`, `b_rdata`[32], `b_rvalid`  out  port B equivalents.
- `mem_address`  out  32  to memory address.
- `mem_writeEnable`  out  1  to memory write enable.
- `mem_dataIn`  out  32  to memory write data.
- `mem_dataOut`  in  32  from memory combinational read data.
- `err`  out  1  misaligned-access pulse (only with `DMEM_ALIGN_CHECK_EN`; tied 0 otherwise).

## Operation
- States: `ARB` (normal arbitration) and `BURST` (B owns memory).
- `ARB`: only one request -> grant it. Both requests -> grant the port that did not win last (round-robin pointer `last`, reset value = B, so A wins first).
- Granted B beat with `b_lock`=1 -> `BURST`, burst counter = 1. Granted B beat with `b_lock`=0 -> stay in/return to `ARB`.
- `BURST`: B has priority. A granted B beat increments the counter. If the counter = `MAX_BURST` and `a_req`=1, the next slot goes to A, the counter clears, and the state stays `BURST`.
- `BURST` idle cycles (`b_req`=0) do not release the lock, but A is granted in any cycle where `b_req`=0.
- Leave `BURST` on a granted B beat with `b_lock`=0.
- Grants are combinational in the cycle the request is accepted. The mux drives the winner's `addr`, `we` and `wdata` onto `mem_*`.
- No grant: `mem_writeEnable`=0, `mem_address`=0, `mem_dataIn`=0.
- Writes commit at the posedge that ends the grant cycle.
- Reads: `mem_dataOut` is captured at that posedge into the winner's `rdata` register, with `rvalid` high for the following cycle.
- `rdata` holds its value until the next read by the same port.
- `resetn`=0 forces `mem_writeEnable`=0 and both grants to 0 in that cycle, regardless of requests.

## Timing
- Grant latency: 0 cycles with no contention. Under contention a requester waits at most 1 cycle in `ARB`, and at most `MAX_BURST` beats while B holds a burst.
- Read latency: `rvalid` and `rdata` appear 1 cycle after `gnt`.
- Back-to-back grants to the same port are allowed, giving 1 access per cycle.
- Reset values: `a_gnt`, `b_gnt`, `a_rvalid`, `b_rvalid`, `err`, `mem_writeEnable` = 0; `a_rdata`, `b_rdata`, `mem_address`, `mem_dataIn` = 0; state `ARB`; counter 0; `last` = B.
- Reset asserted mid-burst: state returns to `ARB` at that edge and the pending beat is dropped; the requester re-requests.
- Counter saturates at `MAX_BURST`; it never wraps.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: a granted access with `addr[1:0]` != 0 is consumed (`gnt`=1) but `mem_writeEnable` stays 0. In the next cycle, `err`=1 for one cycle with that port's `rvalid`=1 and `rdata`=0.
- Not defined: `addr[1:0]` is passed through unchecked (the memory divides by 4) and `err` is constant 0.

## Test plan
- A reads 0x0000000C with no B traffic -> `a_gnt` in the same cycle; next cycle `a_rvalid`=1 and `a_rdata` = preloaded word 3.
- A and B both request continuously with `b_lock`=0 from reset -> grants alternate A, B, A, B; each port has 1 access per 2 cycles.
- B writes 0x00000008 with 0x00000008, then A reads 0x00000008 -> `a_rdata`=0x00000008, which checks write-then-read ordering across ports.
- `MAX_BURST`=4, B locks a 10-beat burst while `a_req` is high -> B gets 4 beats, A gets 1, B gets 4, A gets 1, then B's final beat has `b_lock`=0 and the state returns to `ARB`.
- Reset pulsed during the 3rd locked B write -> no write at that edge, all outputs 0, state `ARB`, and A wins the first contended cycle after reset.
- With `DMEM_ALIGN_CHECK_EN`, A writes 0x00000006 -> `a_gnt`=1, `mem_writeEnable`=0, and next cycle `err`=1, `a_rvalid`=1, `a_rdata`=0; the memory contents are unchanged.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: port A (CPU load/store) and port B (DMA/debug).
// Handshake: a requester raises *_req with stable fields and holds them until it sees *_gnt in the
// same cycle; gnt means the access happened this cycle. Reads return *_rdata with a one-cycle *_rvalid.
interface dmem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_gnt;
    logic [31:0] a_rdata;
    logic        a_rvalid;

    logic        b_req;
    logic        b_we;
    logic        b_lock;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt;
    logic [31:0] b_rdata;
    logic        b_rvalid;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rdata, a_rvalid,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        output b_gnt, b_rdata, b_rvalid
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rdata, a_rvalid,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        input  b_gnt, b_rdata, b_rvalid
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between ports A and B, with B burst locking.
// Optional feature: define DMEM_ALIGN_CHECK_EN to suppress and flag misaligned accesses via err.
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        resetn,
    dmem_arbiter_if.slave bus,
    output logic [31:0] mem_address,
    output logic        mem_writeEnable,
    output logic [31:0] mem_dataIn,
    input  logic [31:0] mem_dataOut,
    output logic        err,
    output logic        dbg_state_o
);
    typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_e;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_e      state_q, state_d;
    logic        last_q, last_d;          // 1 = B won the most recent grant
    logic [7:0]  cnt_q, cnt_d;
    logic        gnt_a, gnt_b;
    logic        mis_a, mis_b;
    logic [31:0] a_rdata_q, b_rdata_q;
    logic        a_rvalid_q, b_rvalid_q;
    logic        err_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_a = |bus.a_addr[1:0];
    assign mis_b = |bus.b_addr[1:0];
`else
    assign mis_a = 1'b0;
    assign mis_b = 1'b0;
`endif

    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (resetn) begin
            unique case (state_q)
                ARB: begin
                    if (bus.a_req && bus.b_req) begin
                        if (last_q) gnt_a = 1'b1;
                        else        gnt_b = 1'b1;
                    end else if (bus.a_req) begin
                        gnt_a = 1'b1;
                    end else if (bus.b_req) begin
                        gnt_b = 1'b1;
                    end
                end
                BURST: begin
                    // A only breaks in once B has used its full quota, or when B is idle.
                    if (bus.b_req && !(bus.a_req && cnt_q == MAX_B)) gnt_b = 1'b1;
                    else if (bus.a_req)                              gnt_a = 1'b1;
                end
                default: ;
            endcase

            if (gnt_a) begin
                last_d = 1'b0;
                if (state_q == BURST && cnt_q == MAX_B) cnt_d = 8'd0;
            end
            if (gnt_b) begin
                last_d = 1'b1;
                if (bus.b_lock) begin
                    state_d = BURST;
                    if (state_q == ARB)     cnt_d = 8'd1;
                    else if (cnt_q != MAX_B) cnt_d = cnt_q + 8'd1;
                end else begin
                    state_d = ARB;
                    cnt_d   = 8'd0;
                end
            end
        end
    end

    always_comb begin
        mem_address     = 32'd0;
        mem_writeEnable = 1'b0;
        mem_dataIn      = 32'd0;
        if (gnt_a) begin
            mem_address     = bus.a_addr;
            mem_writeEnable = bus.a_we && !mis_a;
            mem_dataIn      = bus.a_wdata;
        end else if (gnt_b) begin
            mem_address     = bus.b_addr;
            mem_writeEnable = bus.b_we && !mis_b;
            mem_dataIn      = bus.b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ARB;
            last_q     <= 1'b1;
            cnt_q      <= 8'd0;
            a_rdata_q  <= 32'd0;
            b_rdata_q  <= 32'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            // A suppressed misaligned access still completes, returning zero data.
            a_rvalid_q <= gnt_a && (!bus.a_we || mis_a);
            b_rvalid_q <= gnt_b && (!bus.b_we || mis_b);
            err_q      <= (gnt_a && mis_a) || (gnt_b && mis_b);
            if (gnt_a && mis_a)          a_rdata_q <= 32'd0;
            else if (gnt_a && !bus.a_we) a_rdata_q <= mem_dataOut;
            if (gnt_b && mis_b)          b_rdata_q <= 32'd0;
            else if (gnt_b && !bus.b_we) b_rdata_q <= mem_dataOut;
        end
    end

    assign bus.a_gnt    = gnt_a;
    assign bus.b_gnt    = gnt_b;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign err          = err_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (MAX_BURST=4) with a behavioural single-port memory beside it.
module tb_dmem_arbiter;
    logic        clk;
    logic        resetn;
    logic [31:0] mem_address;
    logic        mem_writeEnable;
    logic [31:0] mem_dataIn;
    logic [31:0] mem_dataOut;
    logic        err;
    logic        dbg_state;

    logic [31:0] mem [64];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .bus             (bus),
        .mem_address     (mem_address),
        .mem_writeEnable (mem_writeEnable),
        .mem_dataIn      (mem_dataIn),
        .mem_dataOut     (mem_dataOut),
        .err             (err),
        .dbg_state_o     (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory: combinational read, write on posedge, word index = byte address / 4
    assign mem_dataOut = mem[mem_address[7:2]];
    always @(posedge clk) begin
        if (mem_writeEnable) mem[mem_address[7:2]] <= mem_dataIn;
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.a_req   = req;
        bus.a_we    = we;
        bus.a_addr  = addr;
        bus.a_wdata = wdata;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.b_req   = req;
        bus.b_we    = we;
        bus.b_lock  = lock;
        bus.b_addr  = addr;
        bus.b_wdata = wdata;
    endtask

    // scoreboard comparison
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    int exp_b [12];
    int bi;
    int na;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        exp_b  = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
        resetn = 1'b0;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);

        // reset overrides live requests
        step(); resetn = 1'b0;
        set_a(1, 0, 32'h4, 0);
        set_b(1, 1, 1, 32'h10, 32'hDEAD_BEEF);
        #1;
        chk("rst_a_gnt", bus.a_gnt, 0);
        chk("rst_b_gnt", bus.b_gnt, 0);
        chk("rst_mem_we", mem_writeEnable, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_din", mem_dataIn, 0);

        // contention from reset: A, B, A, B
        step(); resetn = 1'b1;
        set_a(1, 0, 32'h4, 0);
        set_b(1, 0, 0, 32'h10, 0);
        #1;
        chk("rst_a_rvalid", bus.a_rvalid, 0);
        chk("rst_b_rvalid", bus.b_rvalid, 0);
        chk("rst_a_rdata", bus.a_rdata, 0);
        chk("rst_b_rdata", bus.b_rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_state", dbg_state, 0);
        chk("alt0_a_gnt", bus.a_gnt, 1);
        chk("alt0_b_gnt", bus.b_gnt, 0);
        chk("alt0_addr", mem_address, 32'h4);
        exp_q.push_back(32'h1000_0001);

        step(); #1;
        chk("alt1_a_gnt", bus.a_gnt, 0);
        chk("alt1_b_gnt", bus.b_gnt, 1);
        chk("alt1_addr", mem_address, 32'h10);
        chk("alt1_a_rvalid", bus.a_rvalid, 1);
        chk("alt1_a_rdata", bus.a_rdata, exp_q.pop_front());

        step(); #1;
        chk("alt2_a_gnt", bus.a_gnt, 1);
        chk("alt2_b_gnt", bus.b_gnt, 0);
        chk("alt2_a_rvalid", bus.a_rvalid, 0);
        chk("alt2_b_rvalid", bus.b_rvalid, 1);
        chk("alt2_b_rdata", bus.b_rdata, 32'h1000_0004);

        step(); #1;
        chk("alt3_a_gnt", bus.a_gnt, 0);
        chk("alt3_b_gnt", bus.b_gnt, 1);
        chk("alt3_a_rvalid", bus.a_rvalid, 1);

        // uncontended A read of word 3
        step();
        set_a(1, 0, 32'hC, 0);
        set_b(0, 0, 0, 0, 0);
        #1;
        chk("rd_a_gnt", bus.a_gnt, 1);
        chk("rd_b_gnt", bus.b_gnt, 0);
        chk("rd_addr", mem_address, 32'hC);
        chk("rd_we", mem_writeEnable, 0);
        chk("rd_b_rvalid_prev", bus.b_rvalid, 1);
        exp_q.push_back(32'h1000_0003);

        step(); set_a(0, 0, 0, 0); #1;
        chk("rd_a_rvalid", bus.a_rvalid, 1);
        chk("rd_a_rdata", bus.a_rdata, exp_q.pop_front());

        step(); #1;
        chk("rd_a_rvalid_pulse", bus.a_rvalid, 0);
        chk("rd_a_rdata_hold", bus.a_rdata, 32'h1000_0003);

        // B writes word 2, then A reads it back
        step(); set_b(1, 1, 0, 32'h8, 32'h8); #1;
        chk("wr_b_gnt", bus.b_gnt, 1);
        chk("wr_we", mem_writeEnable, 1);
        chk("wr_addr", mem_address, 32'h8);
        chk("wr_din", mem_dataIn, 32'h8);

        step(); set_b(0, 0, 0, 0, 0); set_a(1, 0, 32'h8, 0); #1;
        chk("wr_a_gnt", bus.a_gnt, 1);
        chk("wr_b_rvalid", bus.b_rvalid, 0);
        exp_q.push_back(32'h8);

        step(); set_a(0, 0, 0, 0); #1;
        chk("wr_a_rvalid", bus.a_rvalid, 1);
        chk("wr_a_rdata", bus.a_rdata, exp_q.pop_front());

        // misaligned A write to 0x6
        step(); set_a(1, 1, 32'h6, 32'hA5A5_A5A5); #1;
        chk("mis_a_gnt", bus.a_gnt, 1);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_we", mem_writeEnable, 0);
`else
        chk("mis_we", mem_writeEnable, 1);
`endif
        step(); set_a(0, 0, 0, 0); #1;
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_err", err, 1);
        chk("mis_a_rvalid", bus.a_rvalid, 1);
        chk("mis_a_rdata", bus.a_rdata, 0);
        chk("mis_mem", mem[1], 32'h1000_0001);
`else
        chk("mis_err", err, 0);
        chk("mis_a_rvalid", bus.a_rvalid, 0);
        chk("mis_a_rdata", bus.a_rdata, 32'h8);
        chk("mis_mem", mem[1], 32'hA5A5_A5A5);
`endif

        // 10-beat locked B burst with A pending: B x4, A, B x4, A, B x2
        bi = 1;
        na = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            set_b(1, 1, (bi != 10), 32'h40 + 32'(4 * (bi - 1)), 32'hB000_0000 + 32'(bi));
            set_a((c >= 1) && (na < 2), 0, 32'h0, 0);
            #1;
            chk($sformatf("burst%0d_b_gnt", c), bus.b_gnt, 32'(exp_b[c]));
            chk($sformatf("burst%0d_a_gnt", c), bus.a_gnt, 32'(exp_b[c] == 0));
            chk($sformatf("burst%0d_state", c), dbg_state, (c == 0) ? 0 : 1);
            if (bus.b_gnt) bi++;
            if (bus.a_gnt) na++;
        end

        // back in ARB with last = B, so contention goes to A
        step(); set_b(1, 0, 0, 32'h14, 0); set_a(1, 0, 32'h0, 0); #1;
        chk("post_burst_a_gnt", bus.a_gnt, 1);
        chk("post_burst_b_gnt", bus.b_gnt, 0);
        chk("post_burst_state", dbg_state, 0);
        chk("burst_mem_first", mem[16], 32'hB000_0001);
        chk("burst_mem_last", mem[25], 32'hB000_000A);

        step(); set_a(0, 0, 0, 0); set_b(0, 0, 0, 0, 0); #1;
        chk("post_burst_a_rdata", bus.a_rdata, 32'h1000_0000);

        // reset during the third locked B write
        step(); set_b(1, 1, 1, 32'h80, 32'hC1); #1;
        chk("rb1_b_gnt", bus.b_gnt, 1);
        step(); set_b(1, 1, 1, 32'h84, 32'hC2); #1;
        chk("rb2_b_gnt", bus.b_gnt, 1);
        chk("rb2_state", dbg_state, 1);
        step(); resetn = 1'b0; set_b(1, 1, 1, 32'h88, 32'hC3); #1;
        chk("rb3_b_gnt", bus.b_gnt, 0);
        chk("rb3_we", mem_writeEnable, 0);
        chk("rb3_addr", mem_address, 0);

        step(); resetn = 1'b1;
        set_a(1, 0, 32'hC, 0);
        set_b(1, 0, 0, 32'h88, 0);
        #1;
        chk("rb_state", dbg_state, 0);
        chk("rb_a_rdata", bus.a_rdata, 0);
        chk("rb_b_rvalid", bus.b_rvalid, 0);
        chk("rb_a_gnt", bus.a_gnt, 1);
        chk("rb_b_gnt", bus.b_gnt, 0);
        chk("rb_mem_kept", mem[34], 32'h1000_0022);
        chk("rb_mem_beat1", mem[32], 32'hC1);

        step(); set_a(0, 0, 0, 0); set_b(0, 0, 0, 0, 0); #1;
        chk("rb_a_rdata_after", bus.a_rdata, 32'h1000_0003);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
